// File: rtl/avalon_mm_master.sv
// Avalon-MM initiator: valid/ready command stream to Avalon read/write transfers with pipelined read tracking.
// Optional waitrequest stall abort is enabled by defining AVALON_MM_MST_TIMEOUT_EN.
module avalon_mm_master #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int MAX_PEND       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_WR,
  input  logic [ADDR_W-1:0]   CMD_ADDR,
  input  logic [DATA_W/8-1:0] CMD_BE,
  input  logic [DATA_W-1:0]   CMD_WDATA,
  output logic                RSP_VALID,
  output logic [DATA_W-1:0]   RSP_DATA,
  output logic                WR_DONE,
  output logic [3:0]          PEND_CNT,
  output logic                ERR_UNEXP,
  output logic                TIMEOUT,
  output logic [ADDR_W-1:0]   AVALON_ADDRESS,
  output logic [DATA_W/8-1:0] AVALON_BYTEENABLE,
  output logic                AVALON_READ,
  output logic                AVALON_WRITE,
  output logic [DATA_W-1:0]   AVALON_WRITEDATA,
  input  logic [DATA_W-1:0]   AVALON_READDATA,
  input  logic                AVALON_READDATAVALID,
  input  logic                AVALON_WAITREQUEST
);
  localparam int         BE_W  = DATA_W / 8;
  localparam logic [3:0] MAX_P = 4'(MAX_PEND);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t     state;
  req_t       cmd_in, req;
  logic       xfer_done, accept, rd_acc, rdv_ok, abort, abort_rd;
  logic [3:0] pend_nxt;

  assign cmd_in            = '{addr: CMD_ADDR, be: CMD_BE, wdata: CMD_WDATA};
  assign AVALON_ADDRESS    = req.addr;
  assign AVALON_BYTEENABLE = req.be;
  assign AVALON_WRITEDATA  = req.wdata;

  // A strobe is always up in REQ, so completion is simply REQ without stall.
  assign xfer_done = (state == S_REQ) & ~AVALON_WAITREQUEST;
  assign CMD_READY = ~RST & (PEND_CNT < MAX_P) & ((state == S_IDLE) | xfer_done);
  assign accept    = CMD_VALID & CMD_READY;
  assign rd_acc    = accept & ~CMD_WR;
  assign rdv_ok    = AVALON_READDATAVALID & (PEND_CNT != 4'd0);

`ifdef AVALON_MM_MST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign abort = (state == S_REQ) & AVALON_WAITREQUEST &
                 (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST || state != S_REQ || !AVALON_WAITREQUEST || abort) to_cnt <= '0;
    else                                                        to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign abort              = 1'b0;
`endif

  assign abort_rd = abort & AVALON_READ;

  // Reads are counted at accept, so an aborted read must give its slot back.
  always_comb begin
    pend_nxt = PEND_CNT;
    if (rd_acc)                         pend_nxt = pend_nxt + 4'd1;
    if (rdv_ok)                         pend_nxt = pend_nxt - 4'd1;
    if (abort_rd && pend_nxt != 4'd0)   pend_nxt = pend_nxt - 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      req          <= '0;
      AVALON_READ  <= 1'b0;
      AVALON_WRITE <= 1'b0;
      RSP_VALID    <= 1'b0;
      RSP_DATA     <= '0;
      WR_DONE      <= 1'b0;
      ERR_UNEXP    <= 1'b0;
      TIMEOUT      <= 1'b0;
      PEND_CNT     <= 4'd0;
    end else begin
      RSP_VALID <= rdv_ok;
      if (rdv_ok) RSP_DATA <= AVALON_READDATA;
      ERR_UNEXP <= AVALON_READDATAVALID & (PEND_CNT == 4'd0);
      WR_DONE   <= xfer_done & AVALON_WRITE;
      TIMEOUT   <= abort;
      PEND_CNT  <= pend_nxt;
      if (accept) begin
        state        <= S_REQ;
        req          <= cmd_in;
        AVALON_READ  <= ~CMD_WR;
        AVALON_WRITE <= CMD_WR;
      end else if (xfer_done || abort) begin
        state        <= S_IDLE;
        AVALON_READ  <= 1'b0;
        AVALON_WRITE <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_avalon_mm_master.sv
// Directed and randomized bench for avalon_mm_master against a queue-based transaction model.
module tb_avalon_mm_master;
  localparam int AW = 16, DW = 32, BW = 4, MAXP = 4, TOC = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          CMD_VALID, CMD_READY, CMD_WR;
  logic [AW-1:0] CMD_ADDR;
  logic [BW-1:0] CMD_BE;
  logic [DW-1:0] CMD_WDATA;
  logic          RSP_VALID;
  logic [DW-1:0] RSP_DATA;
  logic          WR_DONE, ERR_UNEXP, TIMEOUT;
  logic [3:0]    PEND_CNT;
  logic [AW-1:0] AVALON_ADDRESS;
  logic [BW-1:0] AVALON_BYTEENABLE;
  logic          AVALON_READ, AVALON_WRITE;
  logic [DW-1:0] AVALON_WRITEDATA, AVALON_READDATA;
  logic          AVALON_READDATAVALID, AVALON_WAITREQUEST;

  always #5 CLK = ~CLK;

  avalon_mm_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MAXP), .TIMEOUT_CYCLES(TOC)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_BE(CMD_BE), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .WR_DONE(WR_DONE),
    .PEND_CNT(PEND_CNT), .ERR_UNEXP(ERR_UNEXP), .TIMEOUT(TIMEOUT),
    .AVALON_ADDRESS(AVALON_ADDRESS), .AVALON_BYTEENABLE(AVALON_BYTEENABLE),
    .AVALON_READ(AVALON_READ), .AVALON_WRITE(AVALON_WRITE),
    .AVALON_WRITEDATA(AVALON_WRITEDATA), .AVALON_READDATA(AVALON_READDATA),
    .AVALON_READDATAVALID(AVALON_READDATAVALID), .AVALON_WAITREQUEST(AVALON_WAITREQUEST)
  );

  int checks = 0, failures = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } cmd_t;

  cmd_t          cmd_q[$];
  logic [DW-1:0] ret_q[$];
  int            pend_m = 0, stall_run = 0;
  logic          rdv_now, exp_rv = 1'b0, exp_wd = 1'b0;
  logic [DW-1:0] exp_rd = '0;
  logic          prev_stall = 1'b0, prev_rd = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic samp();
    @(negedge CLK);
  endtask

  // One cycle of random traffic: drive, compare against the model, advance the model.
  task automatic rand_cycle(input bit allow_cmd);
    cmd_t c;
    CMD_VALID = allow_cmd && ($urandom % 2 == 0);
    CMD_WR    = $urandom % 2;
    CMD_ADDR  = AW'($urandom);
    CMD_BE    = BW'($urandom);
    CMD_WDATA = $urandom;
    AVALON_WAITREQUEST = (stall_run < 4) && ($urandom % 3 == 0);
    stall_run = AVALON_WAITREQUEST ? stall_run + 1 : 0;
    rdv_now = (ret_q.size() > 0) && ($urandom % 2 == 0);
    AVALON_READDATAVALID = rdv_now;
    AVALON_READDATA = rdv_now ? ret_q.pop_front() : $urandom;
    samp();
    chk("r_rsp_valid", RSP_VALID, exp_rv);
    if (exp_rv) chk("r_rsp_data", RSP_DATA, exp_rd);
    chk("r_wr_done", WR_DONE, exp_wd);
    chk("r_pend", PEND_CNT, pend_m);
    chk("r_err", ERR_UNEXP, 0);
    chk("r_timeout", TIMEOUT, 0);
    chk("r_one_strobe", AVALON_READ & AVALON_WRITE, 0);
    if (pend_m >= MAXP) chk("r_full_ready", CMD_READY, 0);
    if (prev_stall) begin
      chk("r_hold_rd", AVALON_READ, prev_rd);
      chk("r_hold_wr", AVALON_WRITE, !prev_rd);
      chk("r_hold_addr", AVALON_ADDRESS, prev_addr);
    end
    prev_stall = (AVALON_READ | AVALON_WRITE) & AVALON_WAITREQUEST;
    prev_rd    = AVALON_READ;
    prev_addr  = AVALON_ADDRESS;
    exp_wd = 1'b0;
    if ((AVALON_READ | AVALON_WRITE) && !AVALON_WAITREQUEST) begin
      chk("r_cmpl_known", cmd_q.size() > 0, 1);
      if (cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        chk("r_cmpl_kind", AVALON_WRITE, c.wr);
        chk("r_cmpl_addr", AVALON_ADDRESS, c.addr);
        chk("r_cmpl_be", AVALON_BYTEENABLE, c.be);
        if (c.wr) chk("r_cmpl_wdata", AVALON_WRITEDATA, c.wdata);
        else      ret_q.push_back($urandom);
        exp_wd = c.wr;
      end
    end
    if (CMD_VALID && CMD_READY) begin
      c = '{wr: CMD_WR, addr: CMD_ADDR, be: CMD_BE, wdata: CMD_WDATA};
      cmd_q.push_back(c);
      if (!CMD_WR) pend_m++;
    end
    if (rdv_now) pend_m--;
    exp_rv = rdv_now;
    exp_rd = AVALON_READDATA;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, iss;
    logic ok;
    RST = 1'b1; CMD_VALID = 0; CMD_WR = 0; CMD_ADDR = '0; CMD_BE = '0; CMD_WDATA = '0;
    AVALON_READDATA = '0; AVALON_READDATAVALID = 0; AVALON_WAITREQUEST = 0;
    tick(); tick();
    samp();
    chk("rst_ready", CMD_READY, 0);
    chk("rst_read", AVALON_READ, 0);
    chk("rst_write", AVALON_WRITE, 0);
    chk("rst_pend", PEND_CNT, 0);
    chk("rst_rsp", RSP_VALID, 0);
    chk("rst_wrdone", WR_DONE, 0);
    chk("rst_err", ERR_UNEXP, 0);
    chk("rst_timeout", TIMEOUT, 0);
    tick(); RST = 1'b0;
    samp(); chk("post_rst_ready", CMD_READY, 1);
    tick();

    // Single write, no stall
    CMD_VALID = 1; CMD_WR = 1; CMD_ADDR = 16'h0010; CMD_WDATA = 32'hDEADBEEF; CMD_BE = 4'hF;
    samp(); chk("wr_ready", CMD_READY, 1);
    tick(); CMD_VALID = 0;
    samp();
    chk("wr_strobe", AVALON_WRITE, 1);
    chk("wr_noread", AVALON_READ, 0);
    chk("wr_addr", AVALON_ADDRESS, 16'h0010);
    chk("wr_data", AVALON_WRITEDATA, 32'hDEADBEEF);
    chk("wr_be", AVALON_BYTEENABLE, 4'hF);
    chk("wr_done_early", WR_DONE, 0);
    tick(); samp();
    chk("wr_strobe_drop", AVALON_WRITE, 0);
    chk("wr_done", WR_DONE, 1);
    tick();

    // Read held through three stall cycles
    CMD_VALID = 1; CMD_WR = 0; CMD_ADDR = 16'h0020;
    samp(); chk("rd_ready", CMD_READY, 1);
    tick(); CMD_VALID = 0; AVALON_WAITREQUEST = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) AVALON_WAITREQUEST = 0;
      samp();
      chk("rd_stall_read", AVALON_READ, 1);
      chk("rd_stall_addr", AVALON_ADDRESS, 16'h0020);
      chk("rd_stall_pend", PEND_CNT, 1);
      if (i < 3) chk("rd_stall_ready", CMD_READY, 0);
      tick();
    end
    samp(); chk("rd_read_drop", AVALON_READ, 0);
    tick(); AVALON_READDATAVALID = 1; AVALON_READDATA = 32'h12345678;
    samp(); chk("rd_rsp_latency", RSP_VALID, 0);
    tick(); AVALON_READDATAVALID = 0;
    samp();
    chk("rd_rsp_valid", RSP_VALID, 1);
    chk("rd_rsp_data", RSP_DATA, 32'h12345678);
    chk("rd_pend_zero", PEND_CNT, 0);
    tick();

    // Five back-to-back reads against MAX_PEND=4
    acc = 0; iss = 0;
    CMD_VALID = 1; CMD_WR = 0; CMD_ADDR = 16'h0100;
    for (int c = 0; c < 8; c++) begin
      samp(); ok = CMD_READY; iss += int'(AVALON_READ);
      tick();
      if (ok) begin acc++; CMD_ADDR = CMD_ADDR + 16'd4; end
    end
    chk("b2b_accepted", acc, 4);
    chk("b2b_issued", iss, 4);
    samp();
    chk("b2b_full_ready", CMD_READY, 0);
    chk("b2b_full_pend", PEND_CNT, 4);
    tick(); AVALON_READDATAVALID = 1; AVALON_READDATA = 32'hA0A0A0A0;
    samp(); chk("b2b_ret_ready", CMD_READY, 0);
    tick(); AVALON_READDATAVALID = 0;
    samp();
    chk("b2b_fifth_ready", CMD_READY, 1);
    chk("b2b_ret_rsp", RSP_VALID, 1);
    chk("b2b_ret_data", RSP_DATA, 32'hA0A0A0A0);
    tick(); CMD_VALID = 0;
    samp();
    chk("b2b_fifth_read", AVALON_READ, 1);
    chk("b2b_fifth_addr", AVALON_ADDRESS, 16'h0110);
    chk("b2b_fifth_pend", PEND_CNT, 4);
    tick();
    AVALON_READDATAVALID = 1; AVALON_READDATA = 32'hB1;
    tick(); AVALON_READDATA = 32'hB2;
    tick(); AVALON_READDATAVALID = 0;
    samp();
    chk("ret2_pend", PEND_CNT, 2);
    chk("ret2_rsp", RSP_VALID, 1);
    chk("ret2_data", RSP_DATA, 32'hB2);
    tick();

    // Accept and return in the same cycle at PEND_CNT=2
    CMD_VALID = 1; CMD_WR = 0; CMD_ADDR = 16'h0200;
    AVALON_READDATAVALID = 1; AVALON_READDATA = 32'hC0C0;
    samp(); chk("same_ready", CMD_READY, 1);
    tick(); CMD_VALID = 0; AVALON_READDATAVALID = 0;
    samp();
    chk("same_pend", PEND_CNT, 2);
    chk("same_read", AVALON_READ, 1);
    chk("same_addr", AVALON_ADDRESS, 16'h0200);
    tick();
    AVALON_READDATAVALID = 1; tick(); tick(); AVALON_READDATAVALID = 0;
    samp(); chk("drain_pend", PEND_CNT, 0);
    tick();

    // Unexpected return with nothing outstanding
    AVALON_READDATAVALID = 1; AVALON_READDATA = 32'hBAD;
    samp(); tick(); AVALON_READDATAVALID = 0;
    samp();
    chk("unexp_err", ERR_UNEXP, 1);
    chk("unexp_rsp", RSP_VALID, 0);
    chk("unexp_pend", PEND_CNT, 0);
    tick(); samp(); chk("unexp_pulse", ERR_UNEXP, 0);
    tick();

    // Randomized traffic then bounded drain
    for (int n = 0; n < 800; n++) rand_cycle(1'b1);
    for (int n = 0; n < 300 && (cmd_q.size() > 0 || ret_q.size() > 0); n++) rand_cycle(1'b0);
    rand_cycle(1'b0); rand_cycle(1'b0);
    chk("drain_cmds", cmd_q.size(), 0);
    chk("drain_rets", ret_q.size(), 0);
    CMD_VALID = 0; AVALON_WAITREQUEST = 0; AVALON_READDATAVALID = 0;
    samp(); chk("drain_pend_final", PEND_CNT, 0);
    tick();

`ifdef AVALON_MM_MST_TIMEOUT_EN
    // Stuck waitrequest on a read aborts after TIMEOUT_CYCLES stall cycles
    CMD_VALID = 1; CMD_WR = 0; CMD_ADDR = 16'h0300;
    samp(); chk("to_ready", CMD_READY, 1);
    tick(); CMD_VALID = 0; AVALON_WAITREQUEST = 1;
    for (int i = 0; i < TOC; i++) begin
      samp();
      chk("to_read_held", AVALON_READ, 1);
      chk("to_no_pulse", TIMEOUT, 0);
      tick();
    end
    samp();
    chk("to_read_drop", AVALON_READ, 0);
    chk("to_pulse", TIMEOUT, 1);
    chk("to_pend", PEND_CNT, 0);
    tick(); AVALON_WAITREQUEST = 0;
    samp();
    chk("to_pulse_end", TIMEOUT, 0);
    chk("to_rsp", RSP_VALID, 0);
    chk("to_ready_back", CMD_READY, 1);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
